// File: rtl/hex_seq_pkg.sv
// Shared encodings, glyph constants and advance rules for the HEX display code sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package hex_seq_pkg;

  typedef enum logic [1:0] {
    MODE_DEC    = 2'b00,
    MODE_HEX_UP = 2'b01,
    MODE_HEX_DN = 2'b10,
    MODE_MSG    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_e;

  // Glyph codes understood by the downstream 7-segment decoder.
  localparam logic [3:0] GLY_C     = 4'hA;
  localparam logic [3:0] GLY_U     = 4'hB;
  localparam logic [3:0] GLY_I     = 4'hC;
  localparam logic [3:0] GLY_Y     = 4'hD;
  localparam logic [3:0] GLY_H     = 4'hE;
  localparam logic [3:0] GLY_BLANK = 4'hF;

  // Message table: "CU IY H" followed by a trailing blank.
  function automatic logic [3:0] msg_glyph(input logic [2:0] idx);
    logic [3:0] g;
    case (idx)
      3'd0:    g = GLY_C;
      3'd1:    g = GLY_U;
      3'd2:    g = GLY_BLANK;
      3'd3:    g = GLY_I;
      3'd4:    g = GLY_Y;
      3'd5:    g = GLY_BLANK;
      3'd6:    g = GLY_H;
      default: g = GLY_BLANK;
    endcase
    return g;
  endfunction

  // Code shown right after reset or a mode reload.
  function automatic logic [3:0] start_code(input mode_e m);
    logic [3:0] c;
    case (m)
      MODE_HEX_DN: c = 4'hF;
      MODE_MSG:    c = msg_glyph(3'd0);
      default:     c = 4'h0;
    endcase
    return c;
  endfunction

  // Code after one advance. In message mode idx is the current table index.
  function automatic logic [3:0] next_code(input mode_e m, input logic [3:0] c,
                                           input logic [2:0] idx);
    logic [3:0] n;
    case (m)
      MODE_DEC:    n = (c == 4'd9) ? 4'd0 : c + 4'd1;
      MODE_HEX_UP: n = c + 4'd1;
      MODE_HEX_DN: n = c - 4'd1;
      default:     n = msg_glyph(idx + 3'd1);
    endcase
    return n;
  endfunction

  // True when the advance from the current position rolls the sequence over.
  function automatic logic is_wrap(input mode_e m, input logic [3:0] c,
                                   input logic [2:0] idx);
    logic w;
    case (m)
      MODE_DEC:    w = (c == 4'd9);
      MODE_HEX_UP: w = (c == 4'hF);
      MODE_HEX_DN: w = (c == 4'h0);
      default:     w = (idx == 3'd7);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler: counts enabled cycles and flags every TICK_DIV-th one.
// Latency: tick is combinational from the count; count returns to 0 on the tick edge.
// Backpressure: none; clear and a dropped enable force the count to 0.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Free count while enabled; held at zero otherwise, wraps on the terminal value.
  always_ff @(posedge clk) begin
    if (reset || clear || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/hex_code_sequencer.sv
// 4-bit HEX display code sequencer (decimal up / hex up / hex down / message) with run, pause and single step.
// Latency: code and code_tick update on the edge that samples the tick or step rise.
// Backpressure: none; optional wrap_tick output when SEQ_WRAP_FLAG_EN is defined.
module hex_code_sequencer
  import hex_seq_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       run_en,
  input  logic       step,
  input  logic [1:0] mode,
  output logic [3:0] code,
`ifdef SEQ_WRAP_FLAG_EN
  output logic       code_tick,
  output logic       wrap_tick
`else
  output logic       code_tick
`endif
);

  state_e     state, state_nxt;
  logic       step_q;
  logic [1:0] mode_q;
  logic [2:0] msg_idx, msg_idx_nxt;
  logic [3:0] code_nxt;
  logic       code_tick_nxt;
  logic       tick;
  logic       step_rise;
  logic       mode_chg;
  logic       adv;
  logic       pre_en;
  logic       pre_clear;
  mode_e      mode_cur;

  assign mode_cur  = mode_e'(mode);
  assign step_rise = step & ~step_q;
  assign mode_chg  = (mode != mode_q);

  // Count only in RUN; a mode reload or leaving RUN restarts the interval.
  assign pre_en    = (state == S_RUN);
  assign pre_clear = mode_chg | ((state == S_RUN) & ~run_en);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (CLOCK_50),
    .reset (reset),
    .en    (pre_en),
    .clear (pre_clear),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next display values; a mode change wins over any advance.
  always_comb begin
    state_nxt     = state;
    code_nxt      = code;
    msg_idx_nxt   = msg_idx;
    code_tick_nxt = 1'b0;
    adv           = 1'b0;
    if (mode_chg) begin
      code_nxt    = start_code(mode_cur);
      msg_idx_nxt = 3'd0;
    end else begin
      adv = tick | ((state != S_RUN) & step_rise);
      if (adv) begin
        code_nxt      = next_code(mode_cur, code, msg_idx);
        code_tick_nxt = 1'b1;
        if (mode_cur == MODE_MSG) begin
          msg_idx_nxt = msg_idx + 3'd1;
        end
      end
      case (state)
        S_IDLE: begin
          if (run_en) begin
            state_nxt = S_RUN;
          end else if (step_rise) begin
            state_nxt = S_PAUSE;
          end
        end
        S_RUN: begin
          if (!run_en) begin
            state_nxt = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (run_en) begin
            state_nxt = S_RUN;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath registers: edge detect, mode history, message index and outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      step_q    <= 1'b0;
      mode_q    <= mode;
      msg_idx   <= 3'd0;
      code      <= start_code(mode_cur);
      code_tick <= 1'b0;
    end else begin
      step_q    <= step;
      mode_q    <= mode;
      msg_idx   <= msg_idx_nxt;
      code      <= code_nxt;
      code_tick <= code_tick_nxt;
    end
  end

`ifdef SEQ_WRAP_FLAG_EN
  // Wrap flag pulses alongside code_tick when the advance rolls the sequence over.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wrap_tick <= 1'b0;
    end else begin
      wrap_tick <= ~mode_chg & adv & is_wrap(mode_cur, code, msg_idx);
    end
  end
`endif

endmodule

// File: doc/hex_code_sequencer.md
Name: hex_code_sequencer

Overview:
- Upstream feeder for the board's 4-bit to 7-segment HEX decoder.
- Produces a 4-bit display code that advances on a prescaled tick, in one of four modes: decimal up, hex up, hex down, or a fixed message.
- Run/pause level control plus a single-step input, for board demos driven from SW/KEY.
- Output drives the decoder's 4-bit input directly. Code 4'b1111 is the blank glyph.

Parameters:
- TICK_DIV, 50000000, clock cycles per advance in RUN (1 Hz at 50 MHz); legal range 2 to 2^26.
- CNT_W, 26, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- run_en  in  1  level input: 1 = run, 0 = pause.
- step  in  1  level input; each rising edge requests one advance.
- mode  in  2  00 = decimal up 0-9, 01 = hex up 0-F, 10 = hex down F-0, 11 = message.
- code  out  4  current display code (registered).
- code_tick  out  1  one-cycle pulse, high in the cycle `code` takes a new value due to an advance.

Behaviour:
- Reset, sampled on a CLOCK_50 edge with reset=1:
  - state=IDLE, prescaler=0, step_q=0, msg_idx=0, code_tick=0, mode_q=mode.
  - code = start value of the current mode: 00/01 -> 0, 10 -> F, 11 -> MSG[0].
- Reset has priority over every other event. Reset mid-RUN discards the prescaler count.
- Message ROM, 8 entries, index 0-7: A, B, F, C, D, F, E, F. These spell "CU IY H" plus a trailing blank.
- States:
  - IDLE -> RUN when run_en=1.
  - IDLE -> PAUSE on a step rise; that step also advances code.
  - RUN -> PAUSE when run_en=0.
  - PAUSE -> RUN when run_en=1.
  - IDLE is entered only via reset.
- Prescaler:
  - Counts only in RUN; held at 0 in IDLE and PAUSE.
  - tick = (prescaler == TICK_DIV-1); the prescaler returns to 0 on the same edge.
  - The first advance after entering RUN occurs exactly TICK_DIV cycles later.
- Step rise = step & ~step_q, with step_q <= step every cycle.
  - Honoured in IDLE and PAUSE.
  - Ignored in RUN. step_q still tracks, so holding step into PAUSE does not produce a rise.
- Advance (one per tick in RUN, or one per step rise in IDLE/PAUSE):
  - 00: 9 wraps to 0; codes A-F never produced.
  - 01: F wraps to 0.
  - 10: 0 wraps to F.
  - 11: msg_idx increments modulo 8; code = MSG[msg_idx+1].
- Latency: code and code_tick update on the same edge that samples the tick or step rise.
- code_tick is 0 in all other cycles, including mode reloads.
- Mode change (mode != mode_q, mode_q <= mode every cycle):
  - On that edge: code reloads to the new mode's start value, msg_idx=0, prescaler=0, code_tick=0.
  - State is unchanged.
  - A coincident tick or step rise is dropped.
- A run_en fall coincident with a tick: the advance happens, then the state moves to PAUSE.

Optional Feature:
- Macro: SEQ_WRAP_FLAG_EN.
- When defined: adds output port wrap_tick (out, 1). It pulses with code_tick when an advance wraps:
  - 9->0 in mode 00, F->0 in 01, 0->F in 10, msg_idx 7->0 in 11.
  - Reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package hex_seq_pkg holds:
  - Mode encodings MODE_DEC, MODE_HEX_UP, MODE_HEX_DN, MODE_MSG.
  - State encodings S_IDLE, S_RUN, S_PAUSE.
  - Glyph constants GLY_C=A, GLY_U=B, GLY_I=C, GLY_Y=D, GLY_H=E, GLY_BLANK=F.
  - The 8-entry MSG table.
- One natural sub-module: tick_prescaler (enable, clear, TICK_DIV parameter, tick out).

Test Plan (TICK_DIV=4):
- Reset with mode=00, run_en=1 after release -> code=0 held 4 cycles, then 1,2,...,9,0 every 4 cycles; code_tick pulses 10 times per 40 cycles.
- mode=10, run -> code F,E,...,0,F; with SEQ_WRAP_FLAG_EN, wrap_tick coincides with the 0->F transition only.
- mode=11, run 32 cycles -> code sequence A,B,F,C,D,F,E,F,A; msg_idx wraps after entry 7.
- IDLE, step pulsed high 3 cycles then low, repeated twice -> exactly two advances (0->1->2), state PAUSE, prescaler stays 0.
- RUN with prescaler at 2, mode switched 01->00 -> code reloads to 0 with no code_tick; next advance 4 cycles later.
- reset asserted one cycle before a tick in RUN -> no advance; code=start value, code_tick=0, state IDLE.
